btb_assoc: RTL and testbench
============================

BTB_ASSOC -- requirements
Module: btb_assoc

Interface
REQ-001 Parameter SETS, default 64, number of sets; power of two, >= 2.
REQ-002 Parameter WAYS, default 2, ways per set; power of two, >= 1.
REQ-003 Derived IDX = log2(SETS); set index = pc[IDX+1:2]; tag = pc[31:IDX+2]; pc[1:0] ignored.
REQ-004 clk  input  1  sole clock, all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 lookup_valid  input  1  fetch lookup request this cycle.
REQ-007 lookup_pc  input  32  fetch PC to look up.
REQ-008 resp_valid  output  1  response for the lookup issued in the previous cycle.
REQ-009 resp_hit  output  1  tag match on a valid entry.
REQ-010 resp_target  output  32  predicted next PC; 0 when not hit.
REQ-011 upd_valid  input  1  execute-stage BTB write or invalidate this cycle.
REQ-012 upd_pc  input  32  branch PC being updated.
REQ-013 upd_target  input  32  resolved target PC.
REQ-014 upd_inval  input  1  with upd_valid: remove the entry for upd_pc instead of writing.
REQ-015 flush  input  1  clear all entries.

Function
REQ-016 Storage SHALL be flops: per entry valid bit, tag, 32-bit target; per set a victim pointer of log2(WAYS) bits (0 when WAYS=1).
REQ-017 Lookup latency SHALL be one cycle: a lookup in cycle N gives resp_valid=1 in cycle N+1; lookup_valid=0 in N gives resp_valid=0, resp_hit=0, resp_target=0 in N+1.
REQ-018 The block SHALL register lookup_pc. The N+1 response SHALL be computed from the array state after the cycle-N edge, so updates in cycle N are visible.
REQ-019 Same-cycle forwarding: if in N+1 upd_valid=1 and upd_pc index/tag equal the registered lookup PC, the response SHALL reflect that update: hit=1, target=upd_target; if upd_inval=1, hit=0 and target=0.
REQ-020 flush=1 in N+1 SHALL force resp_hit=0 and resp_target=0 in N+1. flush takes priority over forwarding.
REQ-021 At most one way SHALL match per set. The hit way drives resp_target.
REQ-022 Update write, tag present in set: overwrite that way's target. Victim pointer unchanged.
REQ-023 Update write, tag absent: allocate the lowest-index invalid way if one exists, and leave the pointer unchanged. Otherwise replace the way at the victim pointer and increment that pointer mod WAYS.
REQ-024 Update invalidate: if the tag is present, clear that way's valid bit. Otherwise no state change. The victim pointer is unchanged either way.
REQ-025 flush SHALL clear all valid bits and all victim pointers at the edge. If upd_valid=1 in the same cycle, the update is dropped.
REQ-026 A lookup and an update to different sets in the same cycle SHALL proceed independently. There is no backpressure, and every request is accepted.

Reset
REQ-027 While rst_n=0, outputs SHALL immediately be resp_valid=0, resp_hit=0, resp_target=0, regardless of clk.
REQ-028 Reset SHALL clear all valid bits, victim pointers, and the registered lookup state. Tags and targets need not be reset.
REQ-029 A reset asserted mid-operation SHALL discard any pending response. The first lookup after rst_n deasserts SHALL miss.

Verification (SETS=64, WAYS=2)
REQ-030 Cold lookup: reset, then lookup 0x0000_1000 -> next cycle resp_valid=1, hit=0, target=0x0.
REQ-031 Write then read: update 0x1000->0x2000; lookup 0x1000 the next cycle -> hit=1, target=0x0000_2000.
REQ-032 Conflict and round-robin: update 0x1000->A, 0x1100->B, then 0x1200->C (all set 0).
  - 0x1200 evicts way 0.
  - Lookup 0x1000 -> miss; lookup 0x1100 -> hit B; lookup 0x1200 -> hit C.
  - Set-0 pointer = 1.
REQ-033 Forwarding: 0x1000->0x2000 installed; lookup 0x1000 in N; update 0x1000->0x3000 in N+1 -> resp in N+1 hit=1, target=0x3000.
  - Repeat with upd_inval=1 in N+1 -> hit=0, target=0.
REQ-034 Flush: entries installed; flush=1 with update 0x1300->D in the same cycle.
  - Lookups of all prior PCs and 0x1300 -> miss.
  - A following update 0x1000->E allocates way 0.
REQ-035 Async reset: drive rst_n low mid-cycle while resp_valid=1, hit=1.
  - resp_valid, hit, target -> 0 before the next clk edge.
  - After release, lookup 0x1000 -> miss.

Source files
------------

// File: rtl/btb_assoc.sv
// Set-associative branch target buffer.
// Flop-based storage with round-robin replacement per set, a one-cycle
// registered lookup, and same-cycle forwarding of execute-stage updates
// into the outgoing response.
module btb_assoc #(
    parameter int SETS = 64,
    parameter int WAYS = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        lookup_valid,
    input  logic [31:0] lookup_pc,
    output logic        resp_valid,
    output logic        resp_hit,
    output logic [31:0] resp_target,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic [31:0] upd_target,
    input  logic        upd_inval,
    input  logic        flush
);

    localparam int IDX  = $clog2(SETS);
    localparam int TAGW = 30 - IDX;
    // A one-way BTB still needs a legal vector width; the pointer stays 0.
    localparam int PTRW = (WAYS > 1) ? $clog2(WAYS) : 1;

    // Control state (reset) and payload storage (not reset).
    logic [SETS-1:0][WAYS-1:0] valid_q;
    logic [SETS-1:0][PTRW-1:0] ptr_q;
    logic [TAGW-1:0]           tag_q    [SETS][WAYS];
    logic [31:0]               target_q [SETS][WAYS];

    // Registered lookup; pc[1:0] never matters so it is not stored.
    logic        lk_valid_q;
    logic [29:0] lk_pc_q;

    logic [IDX-1:0]  upd_idx;
    logic [TAGW-1:0] upd_tag;
    logic [IDX-1:0]  lk_idx;
    logic [TAGW-1:0] lk_tag;

    assign upd_idx = upd_pc[IDX+1:2];
    assign upd_tag = upd_pc[31:IDX+2];
    assign lk_idx  = lk_pc_q[IDX-1:0];
    assign lk_tag  = lk_pc_q[29:IDX];

    // Byte-offset bits are architecturally ignored.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{lookup_pc[1:0], upd_pc[1:0]};

    logic            upd_hit;
    logic [PTRW-1:0] upd_way;
    logic            free_found;
    logic [PTRW-1:0] free_way;
    logic [PTRW-1:0] wr_way;
    logic            wr_en;
    logic            inval_en;
    logic            ptr_bump;

    // Update-side tag search and lowest-index free-way search.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        upd_hit    = 1'b0;
        upd_way    = '0;
        free_found = 1'b0;
        free_way   = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[upd_idx][w] && tag_q[upd_idx][w] == upd_tag) begin
                upd_hit = 1'b1;
                upd_way = PTRW'(w);
            end
        end
        // Scan downward so the last assignment wins with the lowest index.
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_q[upd_idx][w]) begin
                free_found = 1'b1;
                free_way   = PTRW'(w);
            end
        end
    end

    // Flush drops any concurrent update; invalidates only touch a present tag.
    assign wr_en    = upd_valid && !flush && !upd_inval;
    assign inval_en = upd_valid && !flush && upd_inval && upd_hit;
    assign ptr_bump = wr_en && !upd_hit && !free_found;
    assign wr_way   = upd_hit ? upd_way : (free_found ? free_way : ptr_q[upd_idx]);

    // Valid bits and victim pointers: cleared by reset and by flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            valid_q <= '0;
            ptr_q   <= '0;
        end else if (flush) begin
            valid_q <= '0;
            ptr_q   <= '0;
        end else begin
            if (wr_en) begin
                valid_q[upd_idx][wr_way] <= 1'b1;
            end
            if (inval_en) begin
                valid_q[upd_idx][upd_way] <= 1'b0;
            end
            if (ptr_bump) begin
                ptr_q[upd_idx] <= (WAYS > 1) ? ptr_q[upd_idx] + PTRW'(1) : '0;
            end
        end
    end

    // Tag and target payload written on every accepted update write.
    always_ff @(posedge clk) begin
        // NOTE: payload arrays are not reset; the valid bits alone qualify them.
        if (wr_en) begin
            tag_q[upd_idx][wr_way]    <= upd_tag;
            target_q[upd_idx][wr_way] <= upd_target;
        end
    end

    // Capture the lookup request for next cycle's response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lk_valid_q <= 1'b0;
            lk_pc_q    <= '0;
        end else begin
            lk_valid_q <= lookup_valid;
            lk_pc_q    <= lookup_pc[31:2];
        end
    end

    logic        arr_hit;
    logic [31:0] arr_target;
    logic        fwd_match;

    // Response: array read, then same-cycle update forwarding, then flush override.
    always_comb begin
        arr_hit    = 1'b0;
        arr_target = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[lk_idx][w] && tag_q[lk_idx][w] == lk_tag) begin
                arr_hit    = 1'b1;
                arr_target = target_q[lk_idx][w];
            end
        end
        fwd_match   = upd_valid && (upd_idx == lk_idx) && (upd_tag == lk_tag);
        resp_valid  = lk_valid_q;
        resp_hit    = 1'b0;
        resp_target = '0;
        if (lk_valid_q && !flush) begin
            if (fwd_match) begin
                resp_hit    = !upd_inval;
                resp_target = upd_inval ? 32'h0 : upd_target;
            end else if (arr_hit) begin
                resp_hit    = 1'b1;
                resp_target = arr_target;
            end
        end
    end

endmodule

// File: tb/tb_btb_assoc.sv
// Testbench for btb_assoc (SETS=64, WAYS=2): scoreboard of expected
// responses, pushed when a cycle's stimulus is driven and popped one
// cycle later when the DUT presents that cycle's response.
module tb_btb_assoc;

    logic        clk;
    logic        rst_n;
    logic        lookup_valid;
    logic [31:0] lookup_pc;
    logic        resp_valid;
    logic        resp_hit;
    logic [31:0] resp_target;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic [31:0] upd_target;
    logic        upd_inval;
    logic        flush;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        v;
        logic        h;
        logic [31:0] t;
        string       nm;
    } exp_t;

    exp_t sb[$];

    btb_assoc #(.SETS(64), .WAYS(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .lookup_valid (lookup_valid),
        .lookup_pc    (lookup_pc),
        .resp_valid   (resp_valid),
        .resp_hit     (resp_hit),
        .resp_target  (resp_target),
        .upd_valid    (upd_valid),
        .upd_pc       (upd_pc),
        .upd_target   (upd_target),
        .upd_inval    (upd_inval),
        .flush        (flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock cycle: drive inputs at the falling edge, compare the
    // response owed for the previous cycle's lookup, queue this cycle's.
    task automatic drive_cycle(input logic lv, input logic [31:0] lpc,
                               input logic uv, input logic [31:0] upc,
                               input logic [31:0] ut, input logic ui, input logic fl,
                               input logic ev, input logic eh, input logic [31:0] et,
                               input string nm);
        exp_t e;
        exp_t n;
        @(negedge clk);
        lookup_valid = lv;
        lookup_pc    = lpc;
        upd_valid    = uv;
        upd_pc       = upc;
        upd_target   = ut;
        upd_inval    = ui;
        flush        = fl;
        #1;
        n_checks++;
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL %s: no expected response queued", nm);
        end else begin
            e = sb.pop_front();
            if ({resp_valid, resp_hit, resp_target} !== {e.v, e.h, e.t}) begin
                n_fail++;
                $display("FAIL %s: got valid=%b hit=%b target=%h, want valid=%b hit=%b target=%h",
                         e.nm, resp_valid, resp_hit, resp_target, e.v, e.h, e.t);
            end
        end
        n.v  = ev;
        n.h  = eh;
        n.t  = et;
        n.nm = nm;
        sb.push_back(n);
        @(posedge clk);
    endtask

    task automatic look(input logic [31:0] pc, input logic eh, input logic [31:0] et, input string nm);
        drive_cycle(1'b1, pc, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, eh, et, nm);
    endtask

    task automatic upd(input logic [31:0] pc, input logic [31:0] t, input string nm);
        drive_cycle(1'b0, 32'h0, 1'b1, pc, t, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, nm);
    endtask

    task automatic idle(input string nm);
        drive_cycle(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, nm);
    endtask

    task automatic test_reset();
        exp_t n;
        rst_n        = 1'b0;
        lookup_valid = 1'b0;
        lookup_pc    = '0;
        upd_valid    = 1'b0;
        upd_pc       = '0;
        upd_target   = '0;
        upd_inval    = 1'b0;
        flush        = 1'b0;
        #3;
        n_checks++;
        if ({resp_valid, resp_hit, resp_target} !== 34'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got valid=%b hit=%b target=%h, want all zero",
                     resp_valid, resp_hit, resp_target);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        n.v = 1'b0; n.h = 1'b0; n.t = 32'h0; n.nm = "post_reset_idle";
        sb.push_back(n);
    endtask

    task automatic test_cold();
        look(32'h0000_1000, 1'b0, 32'h0, "cold_miss");
        idle("cold_drain");
    endtask

    task automatic test_write_read();
        upd(32'h0000_1000, 32'h0000_2000, "wr_1000");
        look(32'h0000_1000, 1'b1, 32'h0000_2000, "wr_then_hit");
        // Lookup and update of the same PC in one cycle: next response sees the write.
        drive_cycle(1'b1, 32'h0000_1004, 1'b1, 32'h0000_1004, 32'h0000_2004, 1'b0, 1'b0,
                    1'b1, 1'b1, 32'h0000_2004, "same_cycle_write");
        idle("wr_drain");
    endtask

    task automatic test_conflict();
        upd(32'h0000_1000, 32'h0000_A000, "cf_upd_1000");
        upd(32'h0000_1100, 32'h0000_B000, "cf_upd_1100");
        upd(32'h0000_1200, 32'h0000_C000, "cf_upd_1200");
        look(32'h0000_1000, 1'b0, 32'h0, "cf_1000_evicted");
        look(32'h0000_1100, 1'b1, 32'h0000_B000, "cf_1100_hit");
        look(32'h0000_1200, 1'b1, 32'h0000_C000, "cf_1200_hit");
        // Pointer now at way 1: next conflict must evict 0x1100.
        upd(32'h0000_1300, 32'h0000_D000, "cf_upd_1300");
        look(32'h0000_1100, 1'b0, 32'h0, "rr_1100_evicted");
        look(32'h0000_1200, 1'b1, 32'h0000_C000, "rr_1200_kept");
        look(32'h0000_1300, 1'b1, 32'h0000_D000, "rr_1300_hit");
        // Update to another set alongside a lookup and a pending response.
        drive_cycle(1'b1, 32'h0000_1200, 1'b1, 32'h0000_1008, 32'h0000_E008, 1'b0, 1'b0,
                    1'b1, 1'b1, 32'h0000_C000, "indep_lookup");
        look(32'h0000_1008, 1'b1, 32'h0000_E008, "indep_other_set");
        idle("cf_drain");
    endtask

    task automatic test_forwarding();
        drive_cycle(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, "fw_flush");
        upd(32'h0000_1000, 32'h0000_2000, "fw_install");
        look(32'h0000_1000, 1'b1, 32'h0000_3000, "fwd_write");
        upd(32'h0000_1000, 32'h0000_3000, "fwd_write_upd");
        look(32'h0000_1000, 1'b0, 32'h0, "fwd_inval");
        drive_cycle(1'b0, 32'h0, 1'b1, 32'h0000_1000, 32'h0, 1'b1, 1'b0,
                    1'b0, 1'b0, 32'h0, "fwd_inval_upd");
        look(32'h0000_1000, 1'b0, 32'h0, "after_inval_miss");
        upd(32'h0000_1100, 32'h0000_5000, "fw_install_1100");
        // Flush wins over a matching same-cycle update.
        look(32'h0000_1100, 1'b0, 32'h0, "flush_over_fwd");
        drive_cycle(1'b0, 32'h0, 1'b1, 32'h0000_1100, 32'h0000_6000, 1'b0, 1'b1,
                    1'b0, 1'b0, 32'h0, "flush_fwd_cycle");
        look(32'h0000_1100, 1'b0, 32'h0, "after_flush_fwd_miss");
        idle("fw_drain");
    endtask

    task automatic test_flush();
        upd(32'h0000_1000, 32'h0000_00A1, "fl_upd_1000");
        upd(32'h0000_1100, 32'h0000_00B1, "fl_upd_1100");
        upd(32'h0000_1200, 32'h0000_00C1, "fl_upd_1200");
        upd(32'h0000_1008, 32'h0000_00F1, "fl_upd_1008");
        look(32'h0000_1200, 1'b1, 32'h0000_00C1, "fl_pre_hit");
        idle("fl_gap");
        drive_cycle(1'b0, 32'h0, 1'b1, 32'h0000_1300, 32'h0000_00D1, 1'b0, 1'b1,
                    1'b0, 1'b0, 32'h0, "fl_flush_with_upd");
        look(32'h0000_1000, 1'b0, 32'h0, "fl_1000_miss");
        look(32'h0000_1100, 1'b0, 32'h0, "fl_1100_miss");
        look(32'h0000_1200, 1'b0, 32'h0, "fl_1200_miss");
        look(32'h0000_1008, 1'b0, 32'h0, "fl_1008_miss");
        look(32'h0000_1300, 1'b0, 32'h0, "fl_1300_dropped");
        // Pointer was 1 before flush; after flush the third conflict must evict way 0.
        upd(32'h0000_1000, 32'h0000_00E1, "fl_upd_e");
        upd(32'h0000_1100, 32'h0000_0061, "fl_upd_g");
        upd(32'h0000_1200, 32'h0000_0071, "fl_upd_h");
        look(32'h0000_1000, 1'b0, 32'h0, "fl_way0_evicted");
        look(32'h0000_1100, 1'b1, 32'h0000_0061, "fl_way1_kept");
        look(32'h0000_1200, 1'b1, 32'h0000_0071, "fl_new_hit");
        idle("fl_drain");
    endtask

    task automatic test_async_reset();
        exp_t e;
        upd(32'h0000_1000, 32'h0000_2000, "ar_install");
        look(32'h0000_1000, 1'b1, 32'h0000_2000, "ar_pre_reset_hit");
        #2;
        n_checks++;
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL ar_pre_reset_hit: no expected response queued");
        end else begin
            e = sb.pop_front();
            if ({resp_valid, resp_hit, resp_target} !== {e.v, e.h, e.t}) begin
                n_fail++;
                $display("FAIL %s: got valid=%b hit=%b target=%h, want valid=%b hit=%b target=%h",
                         e.nm, resp_valid, resp_hit, resp_target, e.v, e.h, e.t);
            end
        end
        #1;
        rst_n        = 1'b0;
        lookup_valid = 1'b0;
        upd_valid    = 1'b0;
        flush        = 1'b0;
        #1;
        n_checks++;
        if ({resp_valid, resp_hit, resp_target} !== 34'h0) begin
            n_fail++;
            $display("FAIL ar_outputs_cleared: got valid=%b hit=%b target=%h, want all zero",
                     resp_valid, resp_hit, resp_target);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        e.v = 1'b0; e.h = 1'b0; e.t = 32'h0; e.nm = "ar_post_release_idle";
        sb.push_back(e);
        look(32'h0000_1000, 1'b0, 32'h0, "ar_first_lookup_miss");
        idle("ar_drain");
    endtask

    initial begin
        test_reset();
        test_cold();
        test_write_read();
        test_conflict();
        test_forwarding();
        test_flush();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
